// File: rtl/c2c_rst_pkg.sv
// Shared types and widths for the C2C reset sequencer.
// State encodings are visible on SEQ_STATE and must stay fixed.
package c2c_rst_pkg;

   localparam int unsigned RETRY_W = 4;
   localparam int unsigned LOSS_W  = 8;

   typedef enum logic [2:0] {
      ST_WAIT_LOCK = 3'd0,
      ST_STABLE    = 3'd1,
      ST_C2C_HOLD  = 3'd2,
      ST_WAIT_LINK = 3'd3,
      ST_RUN       = 3'd4,
      ST_FAULT     = 3'd5
   } seq_state_e;

endpackage

// File: rtl/c2c_sync2.sv
// Generic two-flop synchroniser with asynchronous active-low reset.
module c2c_sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/c2c_reset_seq.sv
// Reset/start-up sequencer releasing core and C2C link resets after PLL lock.
// Define RSTSEQ_STATS_EN to add the saturating LOCK_LOSS_CNT port.
module c2c_reset_seq
   import c2c_rst_pkg::*;
#(
   parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
   parameter int unsigned C2C_RST_HOLD        = 16,
   parameter int unsigned LINK_TIMEOUT_CYCLES = 65536,
   parameter int unsigned MAX_RETRIES         = 3
) (
   input  logic               SYSTEM_CLK,
   input  logic               RESET_N,
   input  logic               PLL0_LOCK,
   input  logic               C2C_LINK_UP,
   input  logic               SW_RESTART,
   output logic               CORE_RST_N,
   output logic               C2C_RST_N,
   output logic               FAULT,
   output logic [2:0]         SEQ_STATE,
   output logic [RETRY_W-1:0] RETRY_CNT
`ifdef RSTSEQ_STATS_EN
   ,
   output logic [LOSS_W-1:0]  LOCK_LOSS_CNT
`endif
);

   localparam int unsigned MAX_A = (LOCK_STABLE_CYCLES > C2C_RST_HOLD) ? LOCK_STABLE_CYCLES : C2C_RST_HOLD;
   localparam int unsigned MAX_P = (MAX_A > LINK_TIMEOUT_CYCLES) ? MAX_A : LINK_TIMEOUT_CYCLES;
   localparam int unsigned CW    = $clog2(MAX_P);

   localparam logic [CW-1:0]      STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CW-1:0]      HOLD_LAST   = CW'(C2C_RST_HOLD - 1);
   localparam logic [CW-1:0]      LINK_LAST   = CW'(LINK_TIMEOUT_CYCLES - 1);
   localparam logic [RETRY_W-1:0] RETRY_LIM   = RETRY_W'(MAX_RETRIES);

   seq_state_e         state_q, state_d;
   logic [CW-1:0]      cnt_q;
   logic [RETRY_W-1:0] retry_q, retry_d;
   logic               core_d, c2c_d, fault_d;
   logic               lock_s;
   logic               lock_lost;

   c2c_sync2 u_lock_sync (
      .clk   (SYSTEM_CLK),
      .rst_n (RESET_N),
      .d     (PLL0_LOCK),
      .q     (lock_s)
   );

   assign lock_lost = !lock_s && (state_q != ST_WAIT_LOCK);

   // Outputs are registered from the next state so they change with SEQ_STATE.
   always_ff @(posedge SYSTEM_CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q    <= ST_WAIT_LOCK;
         cnt_q      <= '0;
         retry_q    <= '0;
         CORE_RST_N <= 1'b0;
         C2C_RST_N  <= 1'b0;
         FAULT      <= 1'b0;
      end else begin
         state_q    <= state_d;
         retry_q    <= retry_d;
         CORE_RST_N <= core_d;
         C2C_RST_N  <= c2c_d;
         FAULT      <= fault_d;
         if (state_d != state_q)
            cnt_q <= '0;
         else if (state_q inside {ST_STABLE, ST_C2C_HOLD, ST_WAIT_LINK})
            cnt_q <= cnt_q + CW'(1);
      end
   end

   always_comb begin
      state_d = state_q;
      retry_d = retry_q;
      if (lock_lost) begin
         state_d = ST_WAIT_LOCK;
      end else if (SW_RESTART && (state_q inside {ST_WAIT_LINK, ST_RUN, ST_FAULT})) begin
         state_d = ST_C2C_HOLD;
         retry_d = '0;
      end else begin
         case (state_q)
            ST_WAIT_LOCK: if (lock_s) state_d = ST_STABLE;
            ST_STABLE: begin
               if (cnt_q == STABLE_LAST) begin
                  state_d = ST_C2C_HOLD;
                  retry_d = '0;
               end
            end
            ST_C2C_HOLD: if (cnt_q == HOLD_LAST) state_d = ST_WAIT_LINK;
            ST_WAIT_LINK: begin
               if (C2C_LINK_UP) begin
                  state_d = ST_RUN;
                  retry_d = '0;
               end else if (cnt_q == LINK_LAST) begin
                  state_d = (retry_q < RETRY_LIM) ? ST_C2C_HOLD : ST_FAULT;
                  retry_d = (retry_q == '1) ? retry_q : retry_q + RETRY_W'(1);
               end
            end
            ST_RUN:   if (!C2C_LINK_UP) state_d = ST_C2C_HOLD;
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_WAIT_LOCK;
         endcase
      end
   end

   always_comb begin
      core_d  = state_d inside {ST_C2C_HOLD, ST_WAIT_LINK, ST_RUN, ST_FAULT};
      c2c_d   = state_d inside {ST_WAIT_LINK, ST_RUN};
      fault_d = (state_d == ST_FAULT);
   end

   assign SEQ_STATE = state_q;
   assign RETRY_CNT = retry_q;

`ifdef RSTSEQ_STATS_EN
   logic [LOSS_W-1:0] loss_q;

   always_ff @(posedge SYSTEM_CLK or negedge RESET_N) begin
      if (!RESET_N)
         loss_q <= '0;
      else if (lock_lost && (loss_q != '1))
         loss_q <= loss_q + LOSS_W'(1);
   end

   assign LOCK_LOSS_CNT = loss_q;
`endif

endmodule
